decode_ctrl: RTL and testbench

Instruction decode and control stage between fetch and execute. Accepts 32-bit instructions from fetch over a valid/ready handshake and registers the decoded control word (`alu` op select, register indices, immediate, write and memory enables) toward execute. Holds the architectural Z/N flag register, updated when execute reports a CMP result. Resolves B/BEQ/BGE locally, stalling conditional branches while any CMP is still in flight.

---
 rtl/isa_pkg.sv | 47 ++++
 rtl/flag_tracker.sv | 71 +++++++
 rtl/decode_ctrl.sv | 168 ++++++++++++++++
 tb/tb_decode_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode/control slice: opcodes, instruction
// field positions and the control word handed to execute.
package isa_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_LSL = 4'h4,
        OP_CMP = 4'h5,
        OP_SET = 4'h6,
        OP_LDR = 4'h7,
        OP_STR = 4'h8,
        OP_B   = 4'h9,
        OP_BEQ = 4'hA,
        OP_BGE = 4'hB
    } op_e;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 24;
    localparam int RS1_MSB = 23;
    localparam int RS1_LSB = 20;
    localparam int RS2_MSB = 19;
    localparam int RS2_LSB = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef struct packed {
        logic [3:0]  alu_sel;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [31:0] imm;
        logic        use_imm;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
    } ctrl_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/flag_tracker.sv
// Architectural Z/N flags plus the count of CMPs still in flight, with
// sticky error detection for illegal opcodes and unmatched flag returns.
module flag_tracker
    import isa_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cmp_accept,
    input  logic illegal_accept,
    input  logic flag_valid,
    input  logic flag_zero,
    input  logic flag_negative,
    output logic z,
    output logic n,
    output logic pending_zero,
    output logic pending_full,
    output logic err
);

    localparam logic [PEND_W-1:0] PEND_ONE = 1;

    logic [PEND_W-1:0] pend_q, pend_d;
    logic              z_q, z_d;
    logic              n_q, n_d;
    logic              err_q, err_d;
    logic              flag_ok;

    // A flag return pairs with an older CMP or with one accepted this same cycle.
    always_comb begin
        flag_ok = flag_valid && ((pend_q != '0) || cmp_accept);
        pend_d  = pend_q;
        z_d     = z_q;
        n_d     = n_q;
        err_d   = err_q;
        if (flag_ok) begin
            z_d = flag_zero;
            n_d = flag_negative;
        end
        if (cmp_accept && !flag_ok && (pend_q != '1)) begin
            pend_d = pend_q + PEND_ONE;
        end else if (flag_ok && !cmp_accept) begin
            pend_d = pend_q - PEND_ONE;
        end
        if (illegal_accept || (flag_valid && !flag_ok)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            z_q    <= 1'b0;
            n_q    <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            z_q    <= z_d;
            n_q    <= n_d;
            err_q  <= err_d;
        end
    end

    assign z            = z_q;
    assign n            = n_q;
    assign pending_zero = (pend_q == '0);
    assign pending_full = (pend_q == '1);
    assign err          = err_q;

endmodule

// File: rtl/decode_ctrl.sv
// Decode/control stage: decodes fetched instructions into a registered
// control word for execute and resolves branches locally against Z/N.
module decode_ctrl
    import isa_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [3:0]  ex_alu_sel,
    output logic [3:0]  ex_rd,
    output logic [3:0]  ex_rs1,
    output logic [3:0]  ex_rs2,
    output logic [31:0] ex_imm,
    output logic        ex_use_imm,
    output logic        ex_reg_we,
    output logic        ex_mem_re,
    output logic        ex_mem_we,
    input  logic        flag_valid,
    input  logic        flag_zero,
    input  logic        flag_negative,
    output logic        br_taken,
    output logic [31:0] br_target,
    output logic        err
);

    logic [3:0]  op;
    logic [15:0] imm16;
    ctrl_t       ctrl_dec;
    logic        is_fwd, is_cmp, is_br, is_cbr, is_ill, br_cond;
    logic        z, n, pending_zero, pending_full;
    logic        stall, accept;

    ctrl_t       ctrl_q, ctrl_d;
    logic        ex_valid_q, ex_valid_d;
    logic        br_taken_q, br_taken_d;
    logic [31:0] br_target_q, br_target_d;

    assign op    = if_instr[OP_MSB:OP_LSB];
    assign imm16 = if_instr[IMM_MSB:IMM_LSB];

    always_comb begin
        ctrl_dec         = '0;
        ctrl_dec.alu_sel = op;
        ctrl_dec.rd      = if_instr[RD_MSB:RD_LSB];
        ctrl_dec.rs1     = if_instr[RS1_MSB:RS1_LSB];
        ctrl_dec.rs2     = if_instr[RS2_MSB:RS2_LSB];
        is_fwd           = 1'b0;
        is_cmp           = 1'b0;
        is_br            = 1'b0;
        is_cbr           = 1'b0;
        is_ill           = 1'b0;
        br_cond          = 1'b0;
        case (op_e'(op))
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LSL: begin
                is_fwd          = 1'b1;
                ctrl_dec.reg_we = 1'b1;
            end
            OP_CMP: begin
                is_fwd = 1'b1;
                is_cmp = 1'b1;
            end
            OP_SET: begin
                is_fwd           = 1'b1;
                ctrl_dec.reg_we  = 1'b1;
                ctrl_dec.use_imm = 1'b1;
                ctrl_dec.imm     = {16'h0000, imm16};
            end
            OP_LDR: begin
                is_fwd           = 1'b1;
                ctrl_dec.reg_we  = 1'b1;
                ctrl_dec.mem_re  = 1'b1;
                ctrl_dec.use_imm = 1'b1;
                ctrl_dec.imm     = sext16(imm16);
            end
            OP_STR: begin
                is_fwd           = 1'b1;
                ctrl_dec.mem_we  = 1'b1;
                ctrl_dec.use_imm = 1'b1;
                ctrl_dec.imm     = sext16(imm16);
            end
            OP_B: begin
                is_br   = 1'b1;
                br_cond = 1'b1;
            end
            OP_BEQ: begin
                is_br   = 1'b1;
                is_cbr  = 1'b1;
                br_cond = z;
            end
            OP_BGE: begin
                is_br   = 1'b1;
                is_cbr  = 1'b1;
                br_cond = !n;
            end
            default: is_ill = 1'b1;
        endcase
    end

    // Conditional branches wait out every in-flight CMP so they see final flags.
    assign stall    = if_valid && ((is_cbr && !pending_zero) || (is_cmp && pending_full));
    assign if_ready = (!ex_valid_q || ex_ready) && !stall;
    assign accept   = if_valid && if_ready;

    flag_tracker #(
        .PEND_W(PEND_W)
    ) u_flag_tracker (
        .clk           (clk),
        .rst           (rst),
        .cmp_accept    (accept && is_cmp),
        .illegal_accept(accept && is_ill),
        .flag_valid    (flag_valid),
        .flag_zero     (flag_zero),
        .flag_negative (flag_negative),
        .z             (z),
        .n             (n),
        .pending_zero  (pending_zero),
        .pending_full  (pending_full),
        .err           (err)
    );

    always_comb begin
        ex_valid_d = ex_valid_q;
        ctrl_d     = ctrl_q;
        if (accept && is_fwd) begin
            ex_valid_d = 1'b1;
            ctrl_d     = ctrl_dec;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
        br_taken_d  = accept && is_br && br_cond;
        br_target_d = br_taken_d ? (if_pc + (sext16(imm16) << 2)) : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ctrl_q      <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ctrl_q      <= ctrl_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_alu_sel = ctrl_q.alu_sel;
    assign ex_rd      = ctrl_q.rd;
    assign ex_rs1     = ctrl_q.rs1;
    assign ex_rs2     = ctrl_q.rs2;
    assign ex_imm     = ctrl_q.imm;
    assign ex_use_imm = ctrl_q.use_imm;
    assign ex_reg_we  = ctrl_q.reg_we;
    assign ex_mem_re  = ctrl_q.mem_re;
    assign ex_mem_we  = ctrl_q.mem_we;
    assign br_taken   = br_taken_q;
    assign br_target  = br_target_q;

endmodule

// File: tb/tb_decode_ctrl.sv
// Self-checking bench for decode_ctrl: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model of the stage.
module tb_decode_ctrl;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_alu_sel;
    logic [3:0]  ex_rd;
    logic [3:0]  ex_rs1;
    logic [3:0]  ex_rs2;
    logic [31:0] ex_imm;
    logic        ex_use_imm;
    logic        ex_reg_we;
    logic        ex_mem_re;
    logic        ex_mem_we;
    logic        flag_valid;
    logic        flag_zero;
    logic        flag_negative;
    logic        br_taken;
    logic [31:0] br_target;
    logic        err;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit          m_exv;
    logic [3:0]  m_op, m_rd, m_rs1, m_rs2;
    logic [31:0] m_imm;
    bit          m_use_imm, m_reg_we, m_mem_re, m_mem_we;
    bit          m_br;
    logic [31:0] m_tgt;
    bit          m_z, m_n, m_err;
    int          m_pend;
    localparam int PEND_MAX = 3;

    decode_ctrl #(.PEND_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_ready     (if_ready),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_alu_sel   (ex_alu_sel),
        .ex_rd        (ex_rd),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_imm       (ex_imm),
        .ex_use_imm   (ex_use_imm),
        .ex_reg_we    (ex_reg_we),
        .ex_mem_re    (ex_mem_re),
        .ex_mem_we    (ex_mem_we),
        .flag_valid   (flag_valid),
        .flag_zero    (flag_zero),
        .flag_negative(flag_negative),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mk(input int op, input int rd, input int rs1,
                                       input int rs2, input int imm);
        logic [31:0] w;
        w = {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], imm[15:0]};
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkRegistered();
        checkOutput("ex_valid", 32'(ex_valid), 32'(m_exv));
        if (m_exv) begin
            checkOutput("ex_alu_sel", 32'(ex_alu_sel), 32'(m_op));
            checkOutput("ex_rd", 32'(ex_rd), 32'(m_rd));
            checkOutput("ex_rs1", 32'(ex_rs1), 32'(m_rs1));
            checkOutput("ex_rs2", 32'(ex_rs2), 32'(m_rs2));
            checkOutput("ex_use_imm", 32'(ex_use_imm), 32'(m_use_imm));
            checkOutput("ex_reg_we", 32'(ex_reg_we), 32'(m_reg_we));
            checkOutput("ex_mem_re", 32'(ex_mem_re), 32'(m_mem_re));
            checkOutput("ex_mem_we", 32'(ex_mem_we), 32'(m_mem_we));
            if (m_use_imm) checkOutput("ex_imm", ex_imm, m_imm);
        end
        checkOutput("br_taken", 32'(br_taken), 32'(m_br));
        if (m_br) checkOutput("br_target", br_target, m_tgt);
        checkOutput("err", 32'(err), 32'(m_err));
    endtask

    // Drives one cycle of inputs, checks if_ready, advances the model across
    // the clock edge and checks every registered output afterwards.
    task automatic applyStimulus(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                                 input bit rdy, input bit fv, input bit fz, input bit fn);
        int                 op;
        logic signed [31:0] off;
        bit                 stall, exp_ready, acc, cmpacc;
        if_valid      = v;
        if_instr      = instr;
        if_pc         = pc;
        ex_ready      = rdy;
        flag_valid    = fv;
        flag_zero     = fz;
        flag_negative = fn;
        #1;
        op        = int'(instr[31:28]);
        off       = $signed({{16{instr[15]}}, instr[15:0]});
        stall     = v && (((op == 10 || op == 11) && m_pend != 0) || (op == 5 && m_pend == PEND_MAX));
        exp_ready = (!m_exv || rdy) && !stall;
        checkOutput("if_ready", 32'(if_ready), 32'(exp_ready));
        acc = v && exp_ready;
        m_br  = acc && (op == 9 || (op == 10 && m_z) || (op == 11 && !m_n));
        m_tgt = pc + 32'(off * 4);
        if (acc && op <= 8) begin
            m_exv     = 1;
            m_op      = instr[31:28];
            m_rd      = instr[27:24];
            m_rs1     = instr[23:20];
            m_rs2     = instr[19:16];
            m_reg_we  = (op inside {0, 1, 2, 3, 4, 6, 7});
            m_use_imm = (op inside {6, 7, 8});
            m_mem_re  = (op == 7);
            m_mem_we  = (op == 8);
            m_imm     = (op == 6) ? {16'h0000, instr[15:0]} : off;
        end else if (rdy) begin
            m_exv = 0;
        end
        if (acc && op >= 12) m_err = 1;
        cmpacc = acc && op == 5;
        if (fv) begin
            if (m_pend > 0 || cmpacc) begin
                m_z = fz;
                m_n = fn;
                if (!cmpacc) m_pend--;
            end else begin
                m_err = 1;
            end
        end else if (cmpacc) begin
            m_pend++;
        end
        @(posedge clk);
        #1;
        checkRegistered();
    endtask

    task automatic doReset();
        rst           = 1'b1;
        if_valid      = 1'b0;
        if_instr      = '0;
        if_pc         = '0;
        ex_ready      = 1'b0;
        flag_valid    = 1'b0;
        flag_zero     = 1'b0;
        flag_negative = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_exv  = 0;
        m_br   = 0;
        m_z    = 0;
        m_n    = 0;
        m_err  = 0;
        m_pend = 0;
        checkOutput("rst_ex_valid", 32'(ex_valid), 32'h0);
        checkOutput("rst_alu_sel", 32'(ex_alu_sel), 32'h0);
        checkOutput("rst_rd", 32'(ex_rd), 32'h0);
        checkOutput("rst_imm", ex_imm, 32'h0);
        checkOutput("rst_reg_we", 32'(ex_reg_we), 32'h0);
        checkOutput("rst_br_taken", 32'(br_taken), 32'h0);
        checkOutput("rst_br_target", br_target, 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk);
        doReset();

        // Basic decode of register, zero-extended and sign-extended immediates
        applyStimulus(1, mk(0, 3, 1, 2, 0), 32'h0, 1, 0, 0, 0);
        checkOutput("add_alu_sel", 32'(ex_alu_sel), 32'h0);
        checkOutput("add_reg_we", 32'(ex_reg_we), 32'h1);
        checkOutput("add_rd", 32'(ex_rd), 32'h3);
        checkOutput("add_rs1", 32'(ex_rs1), 32'h1);
        checkOutput("add_rs2", 32'(ex_rs2), 32'h2);
        applyStimulus(1, mk(6, 4, 0, 0, 16'h8001), 32'h4, 1, 0, 0, 0);
        checkOutput("set_imm", ex_imm, 32'h0000_8001);
        applyStimulus(1, mk(7, 5, 1, 0, 16'hFFFC), 32'h8, 1, 0, 0, 0);
        checkOutput("ldr_imm", ex_imm, 32'hFFFF_FFFC);
        checkOutput("ldr_mem_re", 32'(ex_mem_re), 32'h1);
        applyStimulus(0, 32'h0, 32'h0, 1, 0, 0, 0);

        // CMP then BEQ stalled until the flag return three cycles later
        applyStimulus(1, mk(5, 0, 1, 2, 0), 32'hFC, 1, 0, 0, 0);
        applyStimulus(1, mk(10, 0, 0, 0, 4), 32'h100, 1, 0, 0, 0);
        checkOutput("beq_stall", 32'(if_ready), 32'h0);
        applyStimulus(1, mk(10, 0, 0, 0, 4), 32'h100, 1, 0, 0, 0);
        applyStimulus(1, mk(10, 0, 0, 0, 4), 32'h100, 1, 1, 1, 0);
        checkOutput("beq_no_early", 32'(br_taken), 32'h0);
        applyStimulus(1, mk(10, 0, 0, 0, 4), 32'h100, 1, 0, 0, 0);
        checkOutput("beq_taken", 32'(br_taken), 32'h1);
        checkOutput("beq_target", br_target, 32'h0000_0110);
        checkOutput("beq_no_ex", 32'(ex_valid), 32'h0);
        applyStimulus(0, 32'h0, 32'h0, 1, 0, 0, 0);

        // BGE with N=1 falls through, with N=0 goes backward
        applyStimulus(1, mk(5, 0, 1, 2, 0), 32'h38, 1, 0, 0, 0);
        applyStimulus(0, 32'h0, 32'h0, 1, 1, 0, 1);
        applyStimulus(1, mk(11, 0, 0, 0, 16'hFFFF), 32'h40, 1, 0, 0, 0);
        checkOutput("bge_n1", 32'(br_taken), 32'h0);
        applyStimulus(1, mk(5, 0, 1, 2, 0), 32'h38, 1, 0, 0, 0);
        applyStimulus(0, 32'h0, 32'h0, 1, 1, 0, 0);
        applyStimulus(1, mk(11, 0, 0, 0, 16'hFFFF), 32'h40, 1, 0, 0, 0);
        checkOutput("bge_n0", 32'(br_taken), 32'h1);
        checkOutput("bge_target", br_target, 32'h0000_003C);

        // Back-pressure from execute: outputs frozen, nothing lost
        applyStimulus(1, mk(0, 1, 2, 3, 0), 32'h0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, mk(1, 6, 7, 8, 0), 32'h4, 0, 0, 0, 0);
        end
        checkOutput("hold_alu_sel", 32'(ex_alu_sel), 32'h0);
        checkOutput("hold_rd", 32'(ex_rd), 32'h1);
        applyStimulus(1, mk(1, 6, 7, 8, 0), 32'h4, 1, 0, 0, 0);
        checkOutput("rel_sub", 32'(ex_alu_sel), 32'h1);
        applyStimulus(1, mk(2, 9, 10, 11, 0), 32'h8, 1, 0, 0, 0);
        applyStimulus(1, mk(3, 12, 13, 14, 0), 32'hC, 1, 0, 0, 0);
        applyStimulus(0, 32'h0, 32'h0, 1, 0, 0, 0);

        // Fourth outstanding CMP stalls, then reset while stalled
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, mk(5, 0, 1, 2, 0), 32'h0, 1, 0, 0, 0);
        end
        applyStimulus(1, mk(5, 0, 1, 2, 0), 32'h0, 1, 0, 0, 0);
        checkOutput("cmp4_stall", 32'(if_ready), 32'h0);
        doReset();

        // Error sources and stickiness
        applyStimulus(0, 32'h0, 32'h0, 1, 1, 0, 0);
        checkOutput("err_unmatched", 32'(err), 32'h1);
        applyStimulus(1, mk(14, 0, 0, 0, 0), 32'h0, 1, 0, 0, 0);
        checkOutput("ill_no_ex", 32'(ex_valid), 32'h0);
        applyStimulus(0, 32'h0, 32'h0, 1, 0, 0, 0);
        checkOutput("err_sticky", 32'(err), 32'h1);
        doReset();
        applyStimulus(1, mk(14, 0, 0, 0, 0), 32'h0, 1, 0, 0, 0);
        checkOutput("err_illegal", 32'(err), 32'h1);
        doReset();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            int          op;
            logic [31:0] ins;
            bit          fv;
            op  = ($urandom % 16 < 14) ? int'($urandom % 12) : int'(12 + $urandom % 4);
            ins = mk(op, int'($urandom % 16), int'($urandom % 16), int'($urandom % 16),
                     int'($urandom % 65536));
            fv  = (m_pend > 0) ? ($urandom % 3 == 0) : ($urandom % 40 == 0);
            applyStimulus(($urandom % 4) != 0, ins, {$urandom, 2'b00} & 32'hFFFF_FFFC,
                          ($urandom % 4) != 0, fv, 1'($urandom % 2), 1'($urandom % 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
